// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single data-memory port.
// Each grant runs one memory access, bounded by TIMEOUT cycles, and returns a one-cycle ack.
module dmem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,

    output logic        err,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,

    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        winner;
    logic        in_access;
    logic        in_resp;

    // On a tie the requester that was not served last wins; a lone requester always wins.
    assign winner = (m0_req && m1_req) ? ~last_owner_q : m1_req;

    // NOTE: every signal written here gets its default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        err_d        = err_q;

        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d      = ACCESS;
                    owner_d      = winner;
                    last_owner_d = winner;
                    we_d         = winner ? m1_we    : m0_we;
                    addr_d       = winner ? m1_addr  : m0_addr;
                    wdata_d      = winner ? m1_wdata : m0_wdata;
                    cnt_d        = 8'd0;
                    err_d        = 1'b0;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    // An ack in the final allowed cycle still counts as success.
                    state_d = RESP;
                    rdata_d = we_q ? 32'd0 : mem_rdata;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the values from before the edge regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
            cnt_q        <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    // Outputs are decoded from registered state only, and gated to zero outside their phase.
    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    assign mem_en    = in_access;
    assign mem_we    = in_access & we_q;
    assign mem_addr  = in_access ? addr_q  : 32'd0;
    assign mem_wdata = in_access ? wdata_q : 32'd0;

    assign busy      = in_access | in_resp;
    assign owner     = busy & owner_q;

    assign m0_ack    = in_resp & ~owner_q;
    assign m1_ack    = in_resp & owner_q;
    assign m0_rdata  = m0_ack ? rdata_q : 32'd0;
    assign m1_rdata  = m1_ack ? rdata_q : 32'd0;
    assign err       = in_resp & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (TIMEOUT = 4): directed vector table, hand-written
// tie and reset sequences, and randomized transactions against a transaction-level model.
module tb_dmem_arbiter;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack, err;
    logic        mem_en, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        owner, busy;

    int total = 0;
    int bad   = 0;

    // Model state: who was served last, and the memory contents as seen by requesters.
    logic        model_last;
    logic [31:0] mem_model [logic [31:0]];

    typedef struct {
        logic        r0, r1, we0, we1;
        logic [31:0] a0, a1, d0, d1;
        int          lat;          // ACCESS cycles before the memory acks
        bit          scramble;     // change live inputs and drop requests during ACCESS
        logic        exp_owner;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_access;   // number of ACCESS cycles
    } txn_t;

    txn_t vec [7];

    dmem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_all_zero(input string name);
        check(name, 32'({m0_ack, m1_ack, err, mem_en, mem_we, owner, busy}), 32'd0);
        check(name, m0_rdata | m1_rdata | mem_addr | mem_wdata, 32'd0);
    endtask

    task automatic drive_idle();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
    endtask

    // Leaves the bench positioned just after the first rising edge with reset low.
    task automatic apply_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("outs_in_reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("outs_after_reset");
        model_last = 1'b1;
    endtask

    // Runs one transaction from IDLE and returns one cycle after its RESP, back in IDLE.
    task automatic do_txn(input txn_t t, input string tag);
        logic        w;
        logic        ewe;
        logic [31:0] eaddr, ewd;
        int          n_access;
        int          ack_cycle;
        bit          done;

        w     = t.exp_owner;
        ewe   = w ? t.we1 : t.we0;
        eaddr = w ? t.a1  : t.a0;
        ewd   = w ? t.d1  : t.d0;

        m0_req = t.r0; m0_we = t.we0; m0_addr = t.a0; m0_wdata = t.d0;
        m1_req = t.r1; m1_we = t.we1; m1_addr = t.a1; m1_wdata = t.d1;
        mem_ack = 1'b0;

        n_access  = 0;
        ack_cycle = -1;
        done      = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                check({tag, " mem_addr"}, mem_addr, eaddr);
                check({tag, " mem_we"}, 32'(mem_we), 32'(ewe));
                check({tag, " mem_wdata"}, mem_wdata, ewd);
                check({tag, " owner"}, 32'({busy, owner}), 32'({1'b1, w}));
                if (t.scramble) begin
                    m0_addr = 32'h8; m1_addr = 32'h8;
                    m0_wdata = 32'hFFFF_0000; m1_wdata = 32'hFFFF_0000;
                    m0_req = 1'b0; m1_req = 1'b0;
                end
                mem_ack   = (n_access == t.lat);
                mem_rdata = mem_ack ? model_read(mem_addr) : 32'hBAD0_BAD0;
                n_access++;
            end else if (m0_ack || m1_ack) begin
                mem_ack   = 1'b0;
                ack_cycle = c;
                done      = 1'b1;
            end else begin
                mem_ack = 1'b0;
            end
        end

        if (!done) begin
            check({tag, " ack_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, " acks"}, 32'({m1_ack, m0_ack}), w ? 32'd2 : 32'd1);
            check({tag, " rdata"}, w ? m1_rdata : m0_rdata, t.exp_rdata);
            check({tag, " other_rdata"}, w ? m0_rdata : m1_rdata, 32'd0);
            check({tag, " err"}, 32'(err), 32'(t.exp_err));
            check({tag, " n_access"}, 32'(n_access), 32'(t.exp_access));
            check({tag, " latency"}, 32'(ack_cycle), 32'(t.exp_access));
            if (ewe && !t.exp_err) mem_model[eaddr] = ewd;
            model_last = w;
        end

        m0_req = 1'b0;
        m1_req = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " idle_gap"}, 32'({busy, mem_en, m0_ack, m1_ack}), 32'd0);
    endtask

    initial begin
        logic [7:0] busy_exp, owner_exp, a0_exp, a1_exp;
        txn_t       rt;

        mem_model[32'h10] = 32'hDEAD_BEEF;

        //           r0    r1    we0   we1   a0      a1      d0  d1            lat scr   own   err   rdata           acc
        vec[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,  32'h0, 32'h0,        0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1};
        vec[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h4,  32'h0, 32'h1234_5678,2, 1'b1, 1'b1, 1'b0, 32'h0,         3};
        vec[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h4,  32'h10, 32'h0, 32'h0,        1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 2};
        vec[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h4,  32'h10, 32'h0, 32'h0,        0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1};
        vec[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0,  32'h0, 32'h0,        7, 1'b0, 1'b0, 1'b1, 32'h0,         4};
        vec[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h10, 32'h0, 32'h0,        3, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 4};
        vec[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h30, 32'h0, 32'hA5A5_A5A5,0, 1'b0, 1'b1, 1'b0, 32'h0,         1};

        apply_reset();
        for (int i = 0; i < 7; i++) begin
            do_txn(vec[i], $sformatf("vec%0d", i));
        end

        // Both requests held with mem_ack stuck high: m0, m1, m0 with an IDLE gap each time.
        apply_reset();
        m0_req = 1'b1; m1_req = 1'b1;
        m0_addr = 32'h100; m1_addr = 32'h200;
        mem_ack = 1'b1;
        busy_exp  = 8'b1101_1011;
        owner_exp = 8'b0001_1000;
        a0_exp    = 8'b1000_0010;
        a1_exp    = 8'b0001_0000;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("tie%0d busy", k), 32'(busy), 32'(busy_exp[k]));
            check($sformatf("tie%0d owner", k), 32'(owner), 32'(owner_exp[k]));
            check($sformatf("tie%0d acks", k), 32'({m1_ack, m0_ack}), 32'({a1_exp[k], a0_exp[k]}));
        end
        drive_idle();
        @(posedge clk);
        #1;

        // Reset pulse in the second ACCESS cycle; a late mem_ack must not produce an ack.
        apply_reset();
        m0_req = 1'b1; m0_addr = 32'h40;
        @(posedge clk);
        #1;
        check("rst_mid access1", 32'(mem_en), 32'd1);
        @(posedge clk);
        #1;
        check("rst_mid access2", 32'(mem_en), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid immediate", 32'({mem_en, busy}), 32'd0);
        m0_req  = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_mid quiet%0d", k), 32'({m0_ack, m1_ack, err, busy}), 32'd0);
        end
        mem_ack = 1'b0;
        model_last = 1'b1;
        rt = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h14, 32'h0, 32'h0, 0, 1'b0,
               1'b0, 1'b0, model_read(32'h10), 1};
        do_txn(rt, "rst_mid tie");

        // Random transactions predicted from the arbitration and timeout rules.
        for (int n = 0; n < 150; n++) begin
            logic [1:0] rq;
            logic       wsel;
            logic       exp_we;
            rq = 2'($urandom_range(1, 3));
            rt.r0  = rq[0];
            rt.r1  = rq[1];
            rt.we0 = 1'($urandom);
            rt.we1 = 1'($urandom);
            rt.a0  = 32'($urandom_range(0, 7)) << 2;
            rt.a1  = 32'($urandom_range(0, 7)) << 2;
            rt.d0  = $urandom;
            rt.d1  = $urandom;
            rt.lat = $urandom_range(0, 5);
            rt.scramble = 1'($urandom_range(0, 3) == 0);
            wsel   = (rt.r0 && rt.r1) ? ~model_last : rt.r1;
            exp_we = wsel ? rt.we1 : rt.we0;
            rt.exp_owner  = wsel;
            rt.exp_err    = (rt.lat >= TIMEOUT);
            rt.exp_access = (rt.lat >= TIMEOUT) ? TIMEOUT : rt.lat + 1;
            rt.exp_rdata  = (rt.exp_err || exp_we) ? 32'd0 : model_read(wsel ? rt.a1 : rt.a0);
            do_txn(rt, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
